// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Fetches over a req/ack handshake; supports decode stall, branch redirect and flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_npc,
    output logic [15:0] o_if_id_imm
);

    // state | meaning
    // IDLE  | first cycle after reset, no request yet
    // REQ   | fetch request outstanding at r_pc
    // HOLD  | fetched word parked in hold buffer while decode stalls
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_req;
    logic        r_discard;
    logic [31:0] r_target;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_npc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_npc;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_discard_nxt;
    logic [31:0] w_target_nxt;
    logic [31:0] w_hold_instr_nxt;
    logic [31:0] w_hold_npc_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_npc_nxt;
    logic        w_fetch_ok;
    logic        w_release;
    logic [31:0] w_pc_inc;
    logic [31:0] w_br_target;
    logic        w_unused_tgt_bits;

    assign w_pc_inc          = r_pc + 32'd4;
    assign w_br_target       = {i_branch_target[31:2], 2'b00};
    assign w_unused_tgt_bits = ^i_branch_target[1:0];

    // Fetch control: the address stays on r_pc while a request is open, so a
    // redirect without ack is remembered in r_target and applied on the ack.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_discard_nxt    = r_discard;
        w_target_nxt     = r_target;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_npc_nxt   = r_hold_npc;
        w_fetch_ok       = 1'b0;
        w_release        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (i_branch_taken) begin
                    w_pc_nxt     = w_br_target;
                    w_target_nxt = w_br_target;
                end
            end
            S_REQ: begin
                if (i_branch_taken) begin
                    w_target_nxt = w_br_target;
                    if (i_imem_ack) begin
                        w_pc_nxt      = w_br_target;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (i_imem_ack) begin
                    if (r_discard) begin
                        w_pc_nxt      = r_target;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_pc_nxt   = w_pc_inc;
                        w_fetch_ok = 1'b1;
                        if (i_stall && !i_flush) begin
                            w_hold_instr_nxt = i_imem_rdata;
                            w_hold_npc_nxt   = w_pc_inc;
                            w_state_nxt      = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (i_flush || i_branch_taken) begin
                    w_hold_instr_nxt = 32'd0;
                    w_hold_npc_nxt   = 32'd0;
                    w_state_nxt      = S_REQ;
                    if (i_branch_taken) begin
                        w_pc_nxt     = w_br_target;
                        w_target_nxt = w_br_target;
                    end
                end else if (!i_stall) begin
                    w_release        = 1'b1;
                    w_hold_instr_nxt = 32'd0;
                    w_hold_npc_nxt   = 32'd0;
                    w_state_nxt      = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_npc_nxt   = r_npc;
        if (i_flush) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = 32'd0;
            w_npc_nxt   = 32'd0;
        end else if (w_release) begin
            w_valid_nxt = 1'b1;
            w_instr_nxt = r_hold_instr;
            w_npc_nxt   = r_hold_npc;
        end else if (w_fetch_ok && !i_stall) begin
            w_valid_nxt = 1'b1;
            w_instr_nxt = i_imem_rdata;
            w_npc_nxt   = w_pc_inc;
        end else if (!i_stall) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= PC_INIT;
            r_req        <= 1'b0;
            r_discard    <= 1'b0;
            r_target     <= 32'd0;
            r_hold_instr <= 32'd0;
            r_hold_npc   <= 32'd0;
            r_valid      <= 1'b0;
            r_instr      <= 32'd0;
            r_npc        <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_req        <= (w_state_nxt == S_REQ);
            r_discard    <= w_discard_nxt;
            r_target     <= w_target_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_npc   <= w_hold_npc_nxt;
            r_valid      <= w_valid_nxt;
            r_instr      <= w_instr_nxt;
            r_npc        <= w_npc_nxt;
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_if_id_valid = r_valid;
    assign o_if_id_instr = r_instr;
    assign o_if_id_npc   = r_npc;
    assign o_if_id_imm   = r_instr[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ack, stall, flush, br;
    logic [31:0] rdata, tgt;

    logic        req,  valid,  req2,  valid2;
    logic [31:0] addr, instr, npc, addr2, instr2, npc2;
    logic [15:0] imm, imm2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_ack(ack), .i_imem_rdata(rdata),
        .i_stall(stall), .i_flush(flush),
        .i_branch_taken(br), .i_branch_target(tgt),
        .o_if_id_valid(valid), .o_if_id_instr(instr),
        .o_if_id_npc(npc), .o_if_id_imm(imm)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(req2), .o_imem_addr(addr2),
        .i_imem_ack(ack), .i_imem_rdata(rdata),
        .i_stall(stall), .i_flush(flush),
        .i_branch_taken(br), .i_branch_target(tgt),
        .o_if_id_valid(valid2), .o_if_id_instr(instr2),
        .o_if_id_npc(npc2), .o_if_id_imm(imm2)
    );

    // reference model: pending fetch, optional redirect, queue of parked words
    bit          m_boot;
    bit          m_redir_pend;
    logic [31:0] m_pc, m_redir;
    logic [63:0] m_held[$];
    logic        m_valid;
    logic [31:0] m_instr, m_npc;

    task automatic set_in(input logic a, input logic [31:0] d, input logic s,
                          input logic f, input logic b, input logic [31:0] t);
        ack = a; rdata = d; stall = s; flush = f; br = b; tgt = t;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req, addr, valid, instr, npc, imm} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b addr=%h v=%b i=%h n=%h imm=%h want all zero",
                     req, addr, valid, instr, npc, imm);
        end
        n_tests++;
        if ({req2, addr2} !== {1'b0, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL reset_pc_param: got req=%b addr=%h want 0 fffffffc", req2, addr2);
        end
    endtask

    task automatic test_stream;
        do_reset();
        set_in(1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({req, addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL stream_first_req: got req=%b addr=%h v=%b want 1 0 0", req, addr, valid);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_tests++;
            if ({req, addr} !== {1'b1, 32'(4 * k)}) begin
                n_fail++;
                $display("FAIL stream_addr%0d: got %b %h want 1 %h", k, req, addr, 32'(4 * k));
            end
            n_tests++;
            if ({valid, instr, npc, imm} !== {1'b1, 32'h2008_0005, 32'(4 * k), 16'h0005}) begin
                n_fail++;
                $display("FAIL stream_ifid%0d: got v=%b i=%h n=%h imm=%h want 1 20080005 %h 0005",
                         k, valid, instr, npc, imm, 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall;
        set_in(1'b1, 32'h8C09_FFFC, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({req, valid, instr, npc} !== {1'b0, 1'b1, 32'h2008_0005, 32'h0000_000C}) begin
            n_fail++;
            $display("FAIL stall_enter: got req=%b v=%b i=%h n=%h want 0 1 20080005 c", req, valid, instr, npc);
        end
        set_in(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({req, valid, instr} !== {1'b0, 1'b1, 32'h2008_0005}) begin
            n_fail++;
            $display("FAIL stall_keep: got req=%b v=%b i=%h want 0 1 20080005", req, valid, instr);
        end
        stall = 1'b0;
        step();
        n_tests++;
        if ({valid, instr, npc, imm} !== {1'b1, 32'h8C09_FFFC, 32'h0000_0010, 16'hFFFC}) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b i=%h n=%h imm=%h want 1 8c09fffc 10 fffc", valid, instr, npc, imm);
        end
        n_tests++;
        if ({req, addr} !== {1'b1, 32'h0000_0010}) begin
            n_fail++;
            $display("FAIL stall_resume: got req=%b addr=%h want 1 10", req, addr);
        end
    endtask

    task automatic test_flush;
        set_in(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({valid, instr, npc} !== {1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_stall: got v=%b i=%h n=%h want 0 0 0", valid, instr, npc);
        end
        set_in(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        set_in(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({valid, instr, npc, addr} !== {1'b0, 32'h0, 32'h0, 32'h0000_0018}) begin
            n_fail++;
            $display("FAIL flush_ack: got v=%b i=%h n=%h addr=%h want 0 0 0 18", valid, instr, npc, addr);
        end
    endtask

    task automatic test_redirect;
        do_reset();
        step();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0043);
        step();
        n_tests++;
        if ({req, addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_addr_hold: got req=%b addr=%h v=%b want 1 0 0", req, addr, valid);
        end
        br = 1'b0;
        step();
        set_in(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({req, addr, valid, instr} !== {1'b1, 32'h0000_0040, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL redir_drop: got req=%b addr=%h v=%b i=%h want 1 40 0 0", req, addr, valid, instr);
        end
        set_in(1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        set_in(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        step();
        n_tests++;
        if ({req, addr, valid} !== {1'b1, 32'h0000_0100, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_hold: got req=%b addr=%h v=%b want 1 100 0", req, addr, valid);
        end
        set_in(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({valid, instr, npc} !== {1'b1, 32'hBBBB_0002, 32'h0000_0104}) begin
            n_fail++;
            $display("FAIL redir_after_hold: got v=%b i=%h n=%h want 1 bbbb0002 104", valid, instr, npc);
        end
        set_in(1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 1'b1, 32'h0000_0202);
        step();
        n_tests++;
        if ({addr, valid, instr} !== {32'h0000_0200, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL redir_with_ack: got addr=%h v=%b i=%h want 200 0 0", addr, valid, instr);
        end
    endtask

    task automatic test_reset_mid;
        set_in(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        set_in(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req, addr, valid, instr, npc, imm} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_async: got req=%b addr=%h v=%b i=%h n=%h imm=%h want all zero",
                     req, addr, valid, instr, npc, imm);
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({req, valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ack_ignored: got req=%b v=%b want 0 0", req, valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({req, addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_restart: got req=%b addr=%h want 1 0", req, addr);
        end
    endtask

    task automatic test_pc_wrap;
        do_reset();
        set_in(1'b1, 32'h2408_0007, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        n_tests++;
        if ({req2, addr2} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_first: got req=%b addr=%h want 1 fffffffc", req2, addr2);
        end
        step();
        n_tests++;
        if ({valid2, instr2, npc2, imm2, addr2} !== {1'b1, 32'h2408_0007, 32'h0, 16'h0007, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_npc: got v=%b i=%h n=%h imm=%h addr=%h want 1 24080007 0 0007 0",
                     valid2, instr2, npc2, imm2, addr2);
        end
    endtask

    task automatic model_step;
        logic        got;
        logic [63:0] d;
        logic [31:0] t;
        got = 1'b0;
        d   = 64'd0;
        t   = tgt & 32'hFFFF_FFFC;
        if (m_boot) begin
            m_boot = 1'b0;
            if (br) m_pc = t;
        end else if (m_held.size() != 0) begin
            if (flush || br) begin
                m_held.delete();
                if (br) m_pc = t;
            end else if (!stall) begin
                d   = m_held.pop_front();
                got = 1'b1;
            end
        end else if (ack) begin
            if (br) begin
                m_pc = t;
                m_redir_pend = 1'b0;
            end else if (m_redir_pend) begin
                m_pc = m_redir;
                m_redir_pend = 1'b0;
            end else begin
                d    = {rdata, m_pc + 32'd4};
                m_pc = m_pc + 32'd4;
                if (!flush && stall) m_held.push_back(d);
                else if (!flush)     got = 1'b1;
            end
        end else if (br) begin
            m_redir_pend = 1'b1;
            m_redir      = t;
        end
        if (flush) begin
            m_valid = 1'b0; m_instr = 32'd0; m_npc = 32'd0;
        end else if (got) begin
            m_valid = 1'b1; m_instr = d[63:32]; m_npc = d[31:0];
        end else if (!stall) begin
            m_valid = 1'b0; m_instr = 32'd0;
        end
    endtask

    task automatic test_random;
        logic m_req;
        do_reset();
        m_boot = 1'b1; m_redir_pend = 1'b0; m_pc = 32'h0; m_redir = 32'h0;
        m_held.delete();
        m_valid = 1'b0; m_instr = 32'h0; m_npc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            m_req = !m_boot && (m_held.size() == 0);
            n_tests++;
            if (req !== m_req) begin
                n_fail++;
                $display("FAIL rnd_req cyc %0d: got %b want %b", c, req, m_req);
            end
            if (m_req) begin
                n_tests++;
                if (addr !== m_pc) begin
                    n_fail++;
                    $display("FAIL rnd_addr cyc %0d: got %h want %h", c, addr, m_pc);
                end
            end
            n_tests++;
            if ({valid, instr, npc, imm} !== {m_valid, m_instr, m_npc, m_instr[15:0]}) begin
                n_fail++;
                $display("FAIL rnd_ifid cyc %0d: got v=%b i=%h n=%h imm=%h want v=%b i=%h n=%h",
                         c, valid, instr, npc, imm, m_valid, m_instr, m_npc);
            end
            set_in($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 3,
                   $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0, $urandom);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_redirect();
        test_reset_mid();
        test_pc_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
